// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST inference output stage: sizes, FP32
// field positions, argmax FSM state encoding and small FP32 helpers.
package mnist_pkg;

    localparam int N_CLASSES = 10;
    localparam int DW        = 32;
    localparam int IDXW      = 4;

    // IEEE-754 single-precision field positions
    localparam int         EXP_MSB      = 30;
    localparam int         EXP_LSB      = 23;
    localparam int         MANT_MSB     = 22;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    // Argmax FSM encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // True for any NaN (quiet or signalling): all-ones exponent, non-zero mantissa
    function automatic logic fp32_is_nan(input logic [DW-1:0] x);
        return (x[EXP_MSB:EXP_LSB] == EXP_ALL_ONES) && (x[MANT_MSB:0] != '0);
    endfunction

    // True for +0 and -0 alike
    function automatic logic fp32_is_zero(input logic [DW-1:0] x);
        return (x[EXP_MSB:0] == '0);
    endfunction

endpackage

// File: rtl/mnist_fp32_gt.sv
// Combinational strict FP32 greater-than on raw sign-magnitude bits.
// NaN never wins and loses to any ordinary value; +0 equals -0;
// infinities and denormals order by plain bit magnitude.
module mnist_fp32_gt
    import mnist_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          gt
);

    logic          a_sign;
    logic          b_sign;
    logic [DW-2:0] a_mag;
    logic [DW-2:0] b_mag;

    assign a_sign = a[DW-1];
    assign b_sign = b[DW-1];
    assign a_mag  = a[DW-2:0];
    assign b_mag  = b[DW-2:0];

    // Priority: NaN rules first, then signed-zero equality, then ordinary ordering
    always_comb begin
        gt = 1'b0;
        if (fp32_is_nan(a)) begin
            gt = 1'b0;
        end else if (fp32_is_nan(b)) begin
            gt = 1'b1;
        end else if (fp32_is_zero(a) && fp32_is_zero(b)) begin
            gt = 1'b0;
        end else if (a_sign != b_sign) begin
            gt = ~a_sign;
        end else if (!a_sign) begin
            gt = (a_mag > b_mag);
        end else begin
            gt = (a_mag < b_mag);
        end
    end

endmodule

// File: rtl/mnist_argmax_classifier.sv
// Final MNIST stage: captures ten FP32 logits, scans them one compare per
// cycle and presents the winning class index and logit on a valid/ready port.
module mnist_argmax_classifier
    import mnist_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CLASSES*DW-1:0] logits,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [IDXW-1:0]         class_out,
    output logic [DW-1:0]           max_val,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [1:0]              state_q,    state_d;
    logic [N_CLASSES*DW-1:0] cap_q,      cap_d;
    logic [IDXW-1:0]         idx_q,      idx_d;
    logic [IDXW-1:0]         best_idx_q, best_idx_d;
    logic [DW-1:0]           best_val_q, best_val_d;

    logic [DW-1:0]           cur_logit;
    logic                    cur_gt;

    // Select the captured logit addressed by the scan index
    always_comb begin
        cur_logit = '0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (idx_q == IDXW'(i)) begin
                cur_logit = cap_q[i*DW +: DW];
            end
        end
    end

    mnist_fp32_gt u_gt (
        .a  (cur_logit),
        .b  (best_val_q),
        .gt (cur_gt)
    );

    // Next-state: capture in IDLE, one compare per SCAN cycle, hold in DONE until taken
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_d      = logits;
                    best_val_d = logits[DW-1:0];
                    best_idx_d = '0;
                    idx_d      = IDXW'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (cur_gt) begin
                    best_val_d = cur_logit;
                    best_idx_d = idx_q;
                end
                if (idx_q == IDXW'(N_CLASSES-1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any inference in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cap_q      <= '0;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign class_out = best_idx_q;
    assign max_val   = best_val_q;

endmodule

// File: tb/tb_mnist_argmax_classifier.sv
// Self-checking bench for mnist_argmax_classifier: directed scenarios plus
// randomized vectors checked against an ordering-key argmax model.
module tb_mnist_argmax_classifier;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [319:0] logits;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   class_out;
    logic [31:0]  max_val;
    logic         out_valid;
    logic         out_ready;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;
    int accept_cycle = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    mnist_argmax_classifier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .logits    (logits),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .class_out (class_out),
        .max_val   (max_val),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // ---------------- reference model ----------------
    function automatic bit ref_is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Map sign-magnitude onto a signed integer line: -0 and +0 both become 0
    function automatic longint ref_key(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    // Lowest index holding the largest non-NaN value; index 0 if all are NaN
    function automatic logic [3:0] ref_argmax(input logic [319:0] v);
        int     best;
        longint bk;
        logic [31:0] x;
        best = -1;
        bk   = 0;
        for (int i = 0; i < 10; i++) begin
            x = v[i*32 +: 32];
            if (!ref_is_nan(x)) begin
                if (best < 0 || ref_key(x) > bk) begin
                    best = i;
                    bk   = ref_key(x);
                end
            end
        end
        if (best < 0) best = 0;
        return 4'(best);
    endfunction

    function automatic logic [319:0] fill(input logic [31:0] base);
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = base;
        return v;
    endfunction

    function automatic logic [31:0] rand_logit();
        int unsigned p;
        logic [31:0] x;
        logic [31:0] pool [4];
        pool[0] = 32'h3F800000;
        pool[1] = 32'hBF800000;
        pool[2] = 32'h40000000;
        pool[3] = 32'h3F000000;
        p = $urandom_range(0, 9);
        x = $urandom;
        case (p)
            0: x = {x[31], 8'hFF, (x[22:0] == 23'd0) ? 23'd1 : x[22:0]};
            1: x = 32'h7F800000;
            2: x = 32'hFF800000;
            3: x = 32'h00000000;
            4: x = 32'h80000000;
            5, 6: x = pool[$urandom_range(0, 3)];
            7: x = {x[31], 8'h00, x[22:0]};
            default: ;
        endcase
        return x;
    endfunction

    function automatic logic [319:0] rand_vector();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[i*32 +: 32] = rand_logit();
        return v;
    endfunction

    // ---------------- stimulus / check primitives ----------------
    task automatic applyStimulus(input logic [319:0] v, input string name);
        bit ok;
        ok       = 1'b0;
        logits   = v;
        in_valid = 1'b1;
        for (int c = 0; c < 60 && !ok; c++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                accept_cycle = cycle;
                ok = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL %s accept: in_ready actual never 1, required 1", name);
        end
    endtask

    // Called right after the accept edge; expects out_valid after exactly 9 more edges
    task automatic checkOutput(input string name, input logic [319:0] v);
        int n;
        logic [3:0]  exp_idx;
        logic [31:0] exp_val;
        exp_idx = ref_argmax(v);
        exp_val = v[exp_idx*32 +: 32];
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("[TB] FAIL %s latency: actual %0d edges, required 9", name, n);
        end
        vectors++;
        if (class_out !== exp_idx) begin
            miscompares++;
            $display("[TB] FAIL %s class_out: actual %0d, required %0d", name, class_out, exp_idx);
        end
        vectors++;
        if (max_val !== exp_val) begin
            miscompares++;
            $display("[TB] FAIL %s max_val: actual %h, required %h", name, max_val, exp_val);
        end
    endtask

    task automatic consume(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s handoff: out_valid=%b in_ready=%b, required 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic run_vector(input logic [319:0] v, input string name);
        applyStimulus(v, name);
        checkOutput(name, v);
        consume(name);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        logits    = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || class_out !== 4'd0 || max_val !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset: in_ready=%b out_valid=%b class=%0d max=%h, required 1/0/0/0",
                     in_ready, out_valid, class_out, max_val);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_peak();
        logic [319:0] v;
        v = fill(32'h3F800000);
        v[7*32 +: 32] = 32'h40000000;
        run_vector(v, "single_peak");
    endtask

    task automatic test_negatives_tie();
        logic [319:0] v;
        v = fill(32'hC0000000);
        v[3*32 +: 32] = 32'hBF800000;
        v[8*32 +: 32] = 32'hBF800000;
        run_vector(v, "neg_tie");
    endtask

    task automatic test_zero_nan();
        logic [319:0] v;
        v = fill(32'hBF800000);
        v[0*32 +: 32] = 32'h7FC00000;
        v[5*32 +: 32] = 32'h80000000;
        v[6*32 +: 32] = 32'h00000000;
        run_vector(v, "zero_nan");
        run_vector(fill(32'h7FC00000), "all_nan");
    endtask

    task automatic test_backpressure();
        logic [319:0] v1;
        logic [319:0] v2;
        v1 = fill(32'h3F800000);
        v1[2*32 +: 32] = 32'h41000000;
        v2 = fill(32'hBF800000);
        v2[6*32 +: 32] = 32'h3F000000;
        applyStimulus(v1, "bp_first");
        checkOutput("bp_first", v1);
        logits   = v2;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_out !== 4'd2 || max_val !== 32'h41000000) begin
                miscompares++;
                $display("[TB] FAIL bp_hold: out_valid=%b in_ready=%b class=%0d max=%h, required 1/0/2/41000000",
                         out_valid, in_ready, class_out, max_val);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_second_accept: in_ready actual %b, required 0", in_ready);
        end
        checkOutput("bp_second", v2);
        consume("bp_second");
    endtask

    task automatic test_reset_midscan();
        logic [319:0] v;
        v = fill(32'h3F800000);
        v[1*32 +: 32] = 32'h40400000;
        applyStimulus(v, "midscan");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || class_out !== 4'd0 || max_val !== 32'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midscan_reset: out_valid=%b class=%0d max=%h in_ready=%b, required 0/0/0/1",
                     out_valid, class_out, max_val, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = fill(32'h3F800000);
        v[9*32 +: 32] = 32'h7F800000;
        run_vector(v, "after_reset_inf");
    endtask

    task automatic test_random();
        logic [319:0] v;
        for (int k = 0; k < 30; k++) begin
            v = rand_vector();
            applyStimulus(v, "random");
            checkOutput("random", v);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            consume("random");
        end
    endtask

    task automatic test_back_to_back();
        logic [319:0] v;
        int prev;
        out_ready = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            v = rand_vector();
            applyStimulus(v, "b2b");
            if (k > 0) begin
                vectors++;
                if (accept_cycle - prev != 11) begin
                    miscompares++;
                    $display("[TB] FAIL b2b period: actual %0d cycles, required 11", accept_cycle - prev);
                end
            end
            prev = accept_cycle;
            checkOutput("b2b", v);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_negatives_tie();
        test_zero_nan();
        test_backpressure();
        test_reset_midscan();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mnist_argmax_classifier.md
Name: mnist_argmax_classifier

Overview:
- Final stage of the MNIST inference datapath. It sits directly downstream of the ten layer-2 dense nodes.
- It captures the 10 pre-ReLU FP32 logits as one vector and scans them sequentially, one compare per cycle.
- It returns the predicted digit and its winning logit through a valid/ready handshake.

Parameters:
- N_CLASSES, 10, number of logits per inference.
- DW, 32, logit width (IEEE-754 single precision).
- IDXW, 4, class index width, equal to ceil(log2(N_CLASSES)).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- logits  input  N_CLASSES*DW (320)  logit i is at [32i+31:32i], i.e. node i output c.
- in_valid  input  1  logits valid.
- in_ready  output  1  block can accept a vector.
- class_out  output  IDXW  index of the maximum logit.
- max_val  output  DW  value of the maximum logit.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, class_out=0, max_val=0.
  - The capture register, index counter and best registers all reset to 0.
- IDLE state:
  - in_ready=1.
  - On in_valid & in_ready, latch the 320-bit vector.
  - Set best_val=logit0, best_idx=0, idx=1, then go to SCAN.
- SCAN state:
  - in_ready=0.
  - Each cycle, compare the captured logit[idx] against best_val.
  - If gt(logit[idx], best_val) is true, set best_val=logit[idx] and best_idx=idx.
  - idx increments each cycle. When idx==N_CLASSES-1 has been evaluated, go to DONE.
- DONE state:
  - out_valid=1; class_out/max_val drive best_idx/best_val, held stable.
  - On out_ready, deassert out_valid and return to IDLE; in_ready=1 the next cycle.
- Latency:
  - Accept handshake at edge T. SCAN occupies edges T+1..T+9.
  - out_valid rises after edge T+9 and is observed high in cycle T+10.
  - With out_ready tied high, one inference completes every 11 cycles.
- Backpressure: while out_valid=1 and out_ready=0, all outputs are frozen and in_ready stays 0. No new vector is accepted until the result has been taken.
- Compare rule, gt(a,b) (strict FP32 greater-than, sign-magnitude):
  - Both positive: compare magnitude.
  - Both negative: the smaller magnitude wins.
  - Opposite signs: the positive operand wins.
  - +0 and -0 are equal.
- Ties: strict greater-than means the lowest index wins.
- NaN handling (exponent 0xFF, mantissa != 0):
  - A NaN never wins. gt(NaN,x)=0.
  - gt(x,NaN)=1 for any non-NaN x, so a NaN held in logit0 is displaced by the first non-NaN value.
  - All-NaN input gives class 0 with max_val = logit0.
- Infinities compare normally. Denormals are compared by bit magnitude (no flush).
- in_valid during SCAN/DONE is ignored; the upstream source must hold it until in_ready.
- Reset asserted mid-SCAN or in DONE aborts the inference and returns to reset values; no partial result is emitted.

Decomposition:
- Shared package mnist_pkg holds:
  - N_CLASSES, DW, IDXW;
  - FP32 field constants: EXP_MSB=30, EXP_LSB=23, MANT_MSB=22, EXP_ALL_ONES=8'hFF;
  - the state encoding IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
- Sub-module mnist_fp32_gt, purely combinational:
  - inputs a[31:0], b[31:0]; output gt;
  - implements the compare rule above, including zero and NaN handling;
  - is instantiated once in the scan datapath.

Test Plan:
- Single peak: logits all 1.0 (0x3F800000) except logit7=2.0 (0x40000000), out_ready=1 -> class_out=7, max_val=0x40000000, out_valid high exactly 10 cycles after accept.
- Negatives and tie: logits all -2.0 (0xC0000000) except logit3=logit8=-1.0 (0xBF800000) -> class_out=3, max_val=0xBF800000.
- Zero and NaN handling, two vectors:
  - logit0=0x7FC00000 (NaN), logit5=0x80000000 (-0), logit6=0x00000000 (+0), rest -1.0 -> class_out=5, max_val=0x80000000.
  - All ten logits 0x7FC00000 -> class_out=0, max_val=0x7FC00000.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a second in_valid is not accepted; after out_ready pulses, the second vector is accepted on the following cycle.
- Reset mid-scan: pull rst_n low 4 cycles after accept -> out_valid=0, class_out=0, in_ready=1 immediately (async). A new vector with logit9=+inf (0x7F800000) then gives class_out=9.
